imm_gen_pipe: RTL
=================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values are 32 and 64 only.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port flush  input  1  synchronous discard of all buffered entries.
REQ-005 SHALL have port in_valid  input  1  upstream instruction valid.
REQ-006 SHALL have port in_ready  output  1  block can accept an instruction this cycle.
REQ-007 SHALL have port in_inst  input  32  raw instruction word.
REQ-008 SHALL have port out_valid  output  1  out_imm/out_inst hold a valid entry.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the entry this cycle.
REQ-010 SHALL have port out_imm  output  XLEN  generated immediate.
REQ-011 SHALL have port out_inst  output  32  instruction word paired with out_imm.
REQ-012 SHALL have port out_illegal  output  1  opcode has no immediate format (see Configuration).

Function
REQ-013 SHALL accept an entry when in_valid && in_ready, and present it no earlier than the next cycle; minimum latency is 1 cycle.
REQ-014 SHALL hold its entries in a 2-entry skid buffer with states EMPTY, ONE and FULL; out_* SHALL always show the oldest entry.
REQ-015 SHALL drive in_ready = (state != FULL), decoded from registered state only, with no combinational path from out_ready.
REQ-016 SHALL apply these transitions: EMPTY->ONE on accept; ONE->FULL on accept without drain; ONE->EMPTY on drain without accept; ONE->ONE on simultaneous accept and drain; FULL->ONE on drain.
REQ-017 SHALL preserve FIFO order, and SHALL keep out_* stable while out_valid && !out_ready.
REQ-018 SHALL, when flush=1, go to EMPTY on the next edge, drop any same-cycle input, and give flush priority over accept and drain.
REQ-019 SHALL sign-extend every immediate from inst[31] to XLEN bits.
REQ-020 SHALL form an I-type immediate inst[31:20] for opcodes 0000011 (LOAD), 1100111 (JALR) and 0010011 (OP-IMM, non-shift).
REQ-021 SHALL, for an OP-IMM shift (funct3 001/101), zero-extend the shamt: inst[24:20] when XLEN=32, inst[25:20] when XLEN=64; inst[30] is not an immediate bit.
REQ-022 SHALL form an S-type immediate {inst[31:25], inst[11:7]} for opcode 0100011.
REQ-023 SHALL form a B-type immediate {inst[31], inst[7], inst[30:25], inst[11:8], 0} for opcode 1100011.
REQ-024 SHALL form a U-type immediate {inst[31:12], 12'b0}, sign-extended to XLEN, for opcodes 0110111 (LUI) and 0010111 (AUIPC).
REQ-025 SHALL form a J-type immediate {inst[31], inst[19:12], inst[20], inst[30:21], 0} for opcode 1101111.
REQ-026 SHALL treat opcode 0011011 (OP-IMM-32) as I-type with a 5-bit shamt when XLEN=64, and as unsupported when XLEN=32.
REQ-027 SHALL drive out_imm = 0 for any unsupported opcode.

Reset
REQ-028 SHALL, while reset=1, force state EMPTY, out_valid=0, out_imm=0, out_inst=0 and out_illegal=0; in_ready SHALL read 1 from the first edge after reset.
REQ-029 SHALL give reset priority over flush and over all handshakes, discarding any entries in flight.

Configuration
REQ-030 SHALL, with IMM_GEN_PIPE_ILLEGAL_EN defined, store one illegal bit per entry, set for unsupported opcodes and presented on out_illegal.
REQ-031 SHALL, without IMM_GEN_PIPE_ILLEGAL_EN, tie out_illegal to 0 and add no storage for it.

Verification
REQ-032 SHALL cover: XLEN=32, in_inst=0xFFF00093 (ADDI -1) accepted at cycle n -> out_valid at n+1 with out_imm=0xFFFFFFFF.
REQ-033 SHALL cover: in_inst=0x4030D093 (SRAI 3), then 0xFE000EE3 (BEQ -4), then 0x12345037 (LUI) -> out_imm 0x00000003, 0xFFFFFFFC, 0x12345000 in order.
REQ-034 SHALL cover: XLEN=64, in_inst=0x800000B7 (LUI) -> out_imm=0xFFFFFFFF80000000; in_inst=0x03F09093 (SLLI 63) -> out_imm=0x000000000000003F.
REQ-035 SHALL cover: out_ready=0 with 3 back-to-back inputs -> in_ready=0 after the 2nd accept; release -> 1st then 2nd entry drain in order, 3rd accepted only once in_ready returns to 1.
REQ-036 SHALL cover: FULL state with flush=1 and in_valid=1 together -> next cycle out_valid=0, in_ready=1, input dropped.
REQ-037 SHALL cover: macro defined, in_inst=0x0000007F -> out_illegal=1, out_imm=0; macro undefined -> out_illegal=0.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator behind a 2-entry skid buffer (EMPTY/ONE/FULL).
// Define IMM_GEN_PIPE_ILLEGAL_EN to store and present a per-entry illegal-opcode bit.
module imm_gen_pipe #(
  parameter int XLEN = 32  // 32 or 64 only
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [31:0]     out_inst,
  output logic            out_illegal
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e                 state_q, state_d;
  logic [1:0][XLEN-1:0]   imm_q, imm_d;
  logic [1:0][31:0]       inst_q, inst_d;
  logic [31:0]            dec_v;
  logic                   dec_ill;
  logic [XLEN-1:0]        dec_imm;
  logic                   is_shift;
  logic                   accept, drain;

  // Every format fits a signed 32-bit value; widen once at the end.
  always_comb begin
    dec_v    = '0;
    dec_ill  = 1'b0;
    is_shift = (in_inst[13:12] == 2'b01);
    case (in_inst[6:0])
      7'b0000011, 7'b1100111:
        dec_v = {{20{in_inst[31]}}, in_inst[31:20]};
      7'b0010011:
        if (is_shift) dec_v = (XLEN == 64) ? {26'b0, in_inst[25:20]} : {27'b0, in_inst[24:20]};
        else          dec_v = {{20{in_inst[31]}}, in_inst[31:20]};
      7'b0011011:
        if (XLEN == 64) begin
          if (is_shift) dec_v = {27'b0, in_inst[24:20]};
          else          dec_v = {{20{in_inst[31]}}, in_inst[31:20]};
        end else begin
          dec_ill = 1'b1;
        end
      7'b0100011:
        dec_v = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      7'b1100011:
        dec_v = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        dec_v = {in_inst[31:12], 12'b0};
      7'b1101111:
        dec_v = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      default:
        dec_ill = 1'b1;
    endcase
    dec_imm = XLEN'($signed(dec_v));
  end

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;
  assign out_imm   = imm_q[0];
  assign out_inst  = inst_q[0];

`ifdef IMM_GEN_PIPE_ILLEGAL_EN
  logic [1:0] ill_q, ill_d;
  assign out_illegal = ill_q[0];
`else
  logic       dec_ill_unused;
  assign dec_ill_unused = dec_ill;
  assign out_illegal    = 1'b0;
`endif

  // Slot 0 is always the oldest entry; slot 1 only holds the skid entry in FULL.
  always_comb begin
    state_d = state_q;
    imm_d   = imm_q;
    inst_d  = inst_q;
`ifdef IMM_GEN_PIPE_ILLEGAL_EN
    ill_d   = ill_q;
`endif
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          state_d   = ONE;
          imm_d[0]  = dec_imm;
          inst_d[0] = in_inst;
`ifdef IMM_GEN_PIPE_ILLEGAL_EN
          ill_d[0]  = dec_ill;
`endif
        end
        ONE: begin
          if (accept && !drain) begin
            state_d   = FULL;
            imm_d[1]  = dec_imm;
            inst_d[1] = in_inst;
`ifdef IMM_GEN_PIPE_ILLEGAL_EN
            ill_d[1]  = dec_ill;
`endif
          end else if (accept && drain) begin
            imm_d[0]  = dec_imm;
            inst_d[0] = in_inst;
`ifdef IMM_GEN_PIPE_ILLEGAL_EN
            ill_d[0]  = dec_ill;
`endif
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        FULL: if (drain) begin
          state_d   = ONE;
          imm_d[0]  = imm_q[1];
          inst_d[0] = inst_q[1];
`ifdef IMM_GEN_PIPE_ILLEGAL_EN
          ill_d[0]  = ill_q[1];
`endif
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      imm_q   <= '0;
      inst_q  <= '0;
`ifdef IMM_GEN_PIPE_ILLEGAL_EN
      ill_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      imm_q   <= imm_d;
      inst_q  <= inst_d;
`ifdef IMM_GEN_PIPE_ILLEGAL_EN
      ill_q   <= ill_d;
`endif
    end
  end

endmodule
